// File: rtl/ram32x4_controller.sv
// Initiator-side controller for a registered-input single-port RAM.
// Serves client read/write requests and can sweep CLEAR_VALUE into every word.
module ram32x4_controller #(
  parameter int                ADDR_W       = 5,
  parameter int                DATA_W       = 4,
  parameter int                READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clear_start,
  output logic              clear_done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int                WAIT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    READ_WAIT = 2'd1,
    CLEAR     = 2'd2
  } state_e;

  state_e            state_q,      state_d;
  logic [WAIT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic [ADDR_W-1:0] clr_cnt_q,    clr_cnt_d;
  logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,   rsp_data_d;
  logic              clear_done_q, clear_done_d;
  logic              ready_int;
  logic              wren_int;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    rd_addr_d    = rd_addr_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    clear_done_d = 1'b0;
    ready_int    = 1'b0;
    wren_int     = 1'b0;
    mem_address  = req_addr;
    mem_din      = req_data;

    case (state_q)
      IDLE: begin
        // A pending clear_start masks ready, so a simultaneous request simply waits.
        ready_int = !clear_start;
        wren_int  = req_valid && ready_int && req_write;
        if (clear_start) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end else if (req_valid && !req_write) begin
          state_d    = READ_WAIT;
          wait_cnt_d = '0;
          rd_addr_d  = req_addr;
        end
      end

      READ_WAIT: begin
        // Keep presenting the read address so deeper-latency RAMs stay on it.
        mem_address = rd_addr_q;
        wait_cnt_d  = wait_cnt_q + WAIT_W'(1);
        if (wait_cnt_q == WAIT_LAST) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = mem_dout;
        end
      end

      CLEAR: begin
        mem_address = clr_cnt_q;
        mem_din     = CLEAR_VALUE;
        wren_int    = 1'b1;
        clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_LAST) begin
          state_d      = IDLE;
          clear_done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      clr_cnt_q    <= '0;
      rd_addr_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_addr_q    <= rd_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Gating with reset_n keeps the RAM untouched for the whole reset window.
  assign req_ready  = ready_int && reset_n;
  assign mem_wren   = wren_int && reset_n;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign clear_done = clear_done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ram32x4_controller.sv
// Self-checking bench for ram32x4_controller: behavioural 32x4 RAM, a flat
// reference memory, and directed plus randomized request sequences.
module tb_ram32x4_controller;

  localparam int         RL       = 1;
  localparam logic [3:0] CLR_WORD = 4'b0000;

  logic       clk;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       clear_start;
  logic       clear_done;
  logic       busy;
  logic [4:0] mem_address;
  logic [3:0] mem_din;
  logic       mem_wren;
  logic [3:0] mem_dout;

  logic [3:0] ram [32];
  logic [4:0] ram_addr_q;
  logic [3:0] ref_mem [32];

  int checks   = 0;
  int failures = 0;

  ram32x4_controller #(
    .ADDR_W      (5),
    .DATA_W      (4),
    .READ_LATENCY(RL),
    .CLEAR_VALUE (CLR_WORD)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .clear_start(clear_start),
    .clear_done (clear_done),
    .busy       (busy),
    .mem_address(mem_address),
    .mem_din    (mem_din),
    .mem_wren   (mem_wren),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-input RAM: address and write captured at the edge, q follows the captured address.
  always @(posedge clk) begin
    ram_addr_q <= mem_address;
    if (mem_wren) ram[mem_address] <= mem_din;
  end
  assign mem_dout = ram[ram_addr_q];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [4:0] addr,
                               input logic [3:0] data, input logic clr);
    req_valid   = valid;
    req_write   = write;
    req_addr    = addr;
    req_data    = data;
    clear_start = clr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic doWrite(input logic [4:0] addr, input logic [3:0] data);
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0);
    checkOutput($sformatf("wr%0d_ready", addr), req_ready, 1);
    checkOutput($sformatf("wr%0d_wren", addr), mem_wren, 1);
    checkOutput($sformatf("wr%0d_addr", addr), mem_address, addr);
    tick();
    ref_mem[addr] = data;
    checkOutput($sformatf("wr%0d_no_rsp", addr), rsp_valid, 0);
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic waitResponse(input logic [4:0] addr);
    int edges = 0;
    bit got = 0;
    bit stall_ok = 1;
    while (!got && edges < 20) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) stall_ok = 0;
      tick();
      edges++;
      if (rsp_valid === 1'b1) got = 1;
    end
    checkOutput($sformatf("rd%0d_timeout", addr), got, 1);
    checkOutput($sformatf("rd%0d_latency", addr), edges, RL);
    checkOutput($sformatf("rd%0d_data", addr), rsp_data, ref_mem[addr]);
    checkOutput($sformatf("rd%0d_stall", addr), stall_ok, 1);
    checkOutput($sformatf("rd%0d_ready_back", addr), req_ready, 1);
    tick();
    checkOutput($sformatf("rd%0d_one_cycle", addr), rsp_valid, 0);
  endtask

  task automatic doRead(input logic [4:0] addr);
    applyStimulus(1'b1, 1'b0, addr, 4'($urandom), 1'b0);
    checkOutput($sformatf("rd%0d_accept", addr), req_ready, 1);
    checkOutput($sformatf("rd%0d_wren", addr), mem_wren, 0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    waitResponse(addr);
  endtask

  task automatic idle(input int n);
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Stop a hung run with a visible failure rather than spinning forever.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [4:0] a;
    logic [3:0] d;
    bit         seen_done;
    int         n;

    for (int i = 0; i < 32; i++) begin
      ram[i]     = 4'(i);
      ref_mem[i] = 4'(i);
    end

    // Reset with a write request pending: nothing may reach the RAM.
    reset_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd0, 4'hA, 1'b0);
    tick();
    tick();
    checkOutput("rst_wren", mem_wren, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_clear_done", clear_done, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    reset_n = 1'b1;
    idle(1);
    checkOutput("rst_word0", ram[0], ref_mem[0]);
    $display("[TB] reset checks done");

    doWrite(5'd0, 4'b1010);
    doWrite(5'd2, 4'b1111);
    doWrite(5'd5, 4'b0101);
    idle(1);
    doRead(5'd0);
    doRead(5'd2);
    doRead(5'd5);

    doWrite(5'd2, 4'b0000);
    doRead(5'd2);
    doWrite(5'd31, 4'b1001);
    doRead(5'd31);
    idle(3);
    checkOutput("rsp_data_held", rsp_data, 4'b1001);

    for (int i = 0; i < 40; i++) begin
      a = 5'($urandom_range(0, 31));
      d = 4'($urandom);
      case ($urandom_range(0, 2))
        0: doWrite(a, d);
        1: doRead(a);
        default: begin
          doWrite(a, d);
          doRead(a);
        end
      endcase
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    $display("[TB] random traffic done");

    // clear_start while a read is outstanding is ignored.
    d = 4'($urandom_range(1, 15));
    doWrite(5'd12, d);
    applyStimulus(1'b1, 1'b0, 5'd12, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
    checkOutput("rw_clr_busy", busy, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    checkOutput("rw_clr_rsp_valid", rsp_valid, 1);
    checkOutput("rw_clr_rsp_data", rsp_data, ref_mem[12]);
    checkOutput("rw_clr_idle", busy, 0);
    tick();
    checkOutput("rw_clr_no_sweep", busy, 0);

    // Full clear sweep over an all-ones memory, with a read attempt in the middle.
    for (int i = 0; i < 32; i++) doWrite(5'(i), 4'b1111);
    idle(1);
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
    checkOutput("clr_start_ready", req_ready, 0);
    tick();
    for (int i = 0; i < 32; i++) begin
      if (i == 5) applyStimulus(1'b1, 1'b0, 5'd7, 4'd0, 1'b0);
      else        applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
      checkOutput($sformatf("clr%0d_addr", i), mem_address, i);
      checkOutput($sformatf("clr%0d_wren", i), mem_wren, 1);
      checkOutput($sformatf("clr%0d_busy", i), busy, 1);
      checkOutput($sformatf("clr%0d_ready", i), req_ready, 0);
      checkOutput($sformatf("clr%0d_done_early", i), clear_done, 0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    for (int i = 0; i < 32; i++) ref_mem[i] = CLR_WORD;
    checkOutput("clr_done_pulse", clear_done, 1);
    checkOutput("clr_done_busy", busy, 0);
    checkOutput("clr_done_no_rsp", rsp_valid, 0);
    tick();
    checkOutput("clr_done_one_cycle", clear_done, 0);
    checkOutput("clr_read_dropped", rsp_valid, 0);
    doRead(5'd0);
    doRead(5'd17);
    doRead(5'd31);

    // clear_start and a read in the same IDLE cycle: the read waits out the sweep.
    applyStimulus(1'b1, 1'b0, 5'd9, 4'd0, 1'b1);
    checkOutput("coll_ready", req_ready, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd9, 4'd0, 1'b0);
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("coll_sweep_cycles", n, 32);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    waitResponse(5'd9);

    // Reset in the middle of a sweep: words from 10 upward keep their data.
    for (int i = 0; i < 32; i++) doWrite(5'(i), 4'($urandom_range(1, 15)));
    idle(1);
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < 10; i++) ref_mem[i] = CLR_WORD;
    checkOutput("abort_addr10", mem_address, 10);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_wren", mem_wren, 0);
    checkOutput("abort_ready", req_ready, 0);
    tick();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", clear_done, 0);
    checkOutput("abort_rsp", rsp_valid, 0);
    tick();
    reset_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (clear_done === 1'b1) seen_done = 1;
      tick();
    end
    checkOutput("abort_no_done", seen_done, 0);
    checkOutput("abort_idle", busy, 0);
    for (int i = 0; i < 32; i++) doRead(5'(i));

    $display("[TB] all directed steps complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
